// File: rtl/layer_wr_pkg.sv
// Shared constants, state type and width helper for the layer write controller.
package layer_wr_pkg;

  localparam int LAYERS_DEF = 8;
  localparam int WORDS_DEF  = 64;
  localparam int BYTES_DEF  = 3;

  localparam logic [7:0] CMD_WR_START = 8'h2C;
  localparam logic [7:0] CMD_SHOW     = 8'h29;

  typedef enum logic {
    IDLE    = 1'b0,
    WR_DATA = 1'b1
  } wr_state_e;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/layer_wr_if.sv
// Host byte stream in, per-layer RAM write bus out; slave modport is the controller side.
interface layer_wr_if #(
  parameter int LAYERS = 8,
  parameter int WORDS  = 64
);
  localparam int WW = (WORDS > 1) ? $clog2(WORDS) : 1;

  logic              byte_rdy_in;
  logic              dc_in;
  logic [7:0]        byte_data_in;
  logic [LAYERS-1:0] layer_en_out;
  logic [WW-1:0]     word_idx_out;
  logic [3:0]        byte_sel_out;
  logic [7:0]        byte_data_out;
  logic              frame_rdy_out;
  logic              wr_active_out;

  modport master (
    output byte_rdy_in, dc_in, byte_data_in,
    input  layer_en_out, word_idx_out, byte_sel_out, byte_data_out,
           frame_rdy_out, wr_active_out
  );

  modport slave (
    input  byte_rdy_in, dc_in, byte_data_in,
    output layer_en_out, word_idx_out, byte_sel_out, byte_data_out,
           frame_rdy_out, wr_active_out
  );

endinterface

// File: rtl/layer_wr_addr.sv
// Byte/word/layer position counters for the frame being written, with carry chain
// and a flag marking the final byte of the final layer.
module layer_wr_addr
  import layer_wr_pkg::*;
#(
  parameter int LAYERS = LAYERS_DEF,
  parameter int WORDS  = WORDS_DEF,
  parameter int BYTES  = BYTES_DEF,
  localparam int BW = cnt_width(BYTES),
  localparam int WW = cnt_width(WORDS),
  localparam int LW = cnt_width(LAYERS)
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          clear_in,
  input  logic          adv_in,
  output logic [BW-1:0] byte_cnt_out,
  output logic [WW-1:0] word_cnt_out,
  output logic [LW-1:0] layer_cnt_out,
  output logic          last_out
);

  logic [BW-1:0] byte_q, byte_d;
  logic [WW-1:0] word_q, word_d;
  logic [LW-1:0] layer_q, layer_d;
  logic          byte_wrap, word_wrap, layer_wrap;

  assign byte_wrap  = (byte_q  == BW'(BYTES - 1));
  assign word_wrap  = (word_q  == WW'(WORDS - 1));
  assign layer_wrap = (layer_q == LW'(LAYERS - 1));

  always_comb begin
    byte_d  = byte_q;
    word_d  = word_q;
    layer_d = layer_q;
    if (clear_in) begin
      byte_d  = '0;
      word_d  = '0;
      layer_d = '0;
    end else if (adv_in) begin
      if (byte_wrap) begin
        byte_d = '0;
        if (word_wrap) begin
          word_d  = '0;
          layer_d = layer_wrap ? '0 : layer_q + 1'b1;
        end else begin
          word_d = word_q + 1'b1;
        end
      end else begin
        byte_d = byte_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      byte_q  <= '0;
      word_q  <= '0;
      layer_q <= '0;
    end else begin
      byte_q  <= byte_d;
      word_q  <= word_d;
      layer_q <= layer_d;
    end
  end

  assign byte_cnt_out  = byte_q;
  assign word_cnt_out  = word_q;
  assign layer_cnt_out = layer_q;
  assign last_out      = byte_wrap & word_wrap & layer_wrap;

endmodule

// File: rtl/layer_wr_ctl.sv
// Parses host command/data bytes into per-layer RAM writes and frame-ready strobes.
// Optional FRAME_AUTO_SHOW_EN: finishing the last layer also pulses frame_rdy_out.
module layer_wr_ctl
  import layer_wr_pkg::*;
#(
  parameter int LAYERS = LAYERS_DEF,
  parameter int WORDS  = WORDS_DEF,
  parameter int BYTES  = BYTES_DEF
) (
  input logic       clk_in,
  input logic       rst_in,
  layer_wr_if.slave bus
);

  localparam int BW = cnt_width(BYTES);
  localparam int WW = cnt_width(WORDS);
  localparam int LW = cnt_width(LAYERS);

`ifdef FRAME_AUTO_SHOW_EN
  localparam bit AUTO_SHOW = 1'b1;
`else
  localparam bit AUTO_SHOW = 1'b0;
`endif

  wr_state_e         state_q, state_d;
  logic [LAYERS-1:0] layer_en_q, layer_en_d;
  logic [WW-1:0]     word_idx_q, word_idx_d;
  logic [3:0]        byte_sel_q, byte_sel_d;
  logic [7:0]        byte_data_q, byte_data_d;
  logic              frame_rdy_q, frame_rdy_d;
  logic              finish_q, finish_d;

  logic              cnt_clear, cnt_adv, cnt_last;
  logic [BW-1:0]     byte_cnt;
  logic [WW-1:0]     word_cnt;
  logic [LW-1:0]     layer_cnt;

  layer_wr_addr #(
    .LAYERS (LAYERS),
    .WORDS  (WORDS),
    .BYTES  (BYTES)
  ) u_addr (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .clear_in      (cnt_clear),
    .adv_in        (cnt_adv),
    .byte_cnt_out  (byte_cnt),
    .word_cnt_out  (word_cnt),
    .layer_cnt_out (layer_cnt),
    .last_out      (cnt_last)
  );

  // layer_en follows the layer counter, so it moves one cycle after the carry write.
  always_comb begin
    state_d     = state_q;
    layer_en_d  = layer_en_q;
    word_idx_d  = word_idx_q;
    byte_sel_d  = '0;
    byte_data_d = byte_data_q;
    frame_rdy_d = 1'b0;
    finish_d    = 1'b0;
    cnt_clear   = 1'b0;
    cnt_adv     = 1'b0;

    if (state_q == WR_DATA) begin
      layer_en_d = LAYERS'(1) << layer_cnt;
    end

    if (finish_q) begin
      state_d     = IDLE;
      layer_en_d  = '0;
      frame_rdy_d = AUTO_SHOW;
    end

    if (bus.byte_rdy_in) begin
      if (!bus.dc_in) begin
        case (bus.byte_data_in)
          CMD_WR_START: begin
            state_d    = WR_DATA;
            layer_en_d = LAYERS'(1);
            cnt_clear  = 1'b1;
          end
          CMD_SHOW: frame_rdy_d = 1'b1;
          default: begin
            if (state_q == WR_DATA) begin
              state_d    = IDLE;
              layer_en_d = '0;
            end
          end
        endcase
      end else if (state_q == WR_DATA && !finish_q) begin
        byte_sel_d  = 4'b0001 << byte_cnt;
        byte_data_d = bus.byte_data_in;
        word_idx_d  = word_cnt;
        cnt_adv     = 1'b1;
        finish_d    = cnt_last;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= IDLE;
      layer_en_q  <= '0;
      word_idx_q  <= '0;
      byte_sel_q  <= '0;
      byte_data_q <= '0;
      frame_rdy_q <= 1'b0;
      finish_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      layer_en_q  <= layer_en_d;
      word_idx_q  <= word_idx_d;
      byte_sel_q  <= byte_sel_d;
      byte_data_q <= byte_data_d;
      frame_rdy_q <= frame_rdy_d;
      finish_q    <= finish_d;
    end
  end

  assign bus.layer_en_out  = layer_en_q;
  assign bus.word_idx_out  = word_idx_q;
  assign bus.byte_sel_out  = byte_sel_q;
  assign bus.byte_data_out = byte_data_q;
  assign bus.frame_rdy_out = frame_rdy_q;
  assign bus.wr_active_out = (state_q == WR_DATA);

endmodule

// File: tb/tb_layer_wr_ctl.sv
// Randomized bench for layer_wr_ctl, checked against a frame-position reference model.
// Honours FRAME_AUTO_SHOW_EN the same way as the design.
module tb_layer_wr_ctl;

  localparam int LAYERS      = 8;
  localparam int WORDS       = 64;
  localparam int BYTES       = 3;
  localparam int LAYER_BYTES = WORDS * BYTES;
  localparam int FRAME_BYTES = LAYERS * LAYER_BYTES;

`ifdef FRAME_AUTO_SHOW_EN
  localparam int AUTO_PULSES = 1;
`else
  localparam int AUTO_PULSES = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   frame_pulses = 0;

  // Reference model: whether a frame is open and the linear byte position within it.
  bit                m_active = 1'b0;
  int                m_pos = 0;
  logic [3:0]        e_sel;
  logic [LAYERS-1:0] e_en;
  logic [5:0]        e_word;
  bit                e_last;

  layer_wr_if #(.LAYERS(LAYERS), .WORDS(WORDS)) bus ();

  layer_wr_ctl #(.LAYERS(LAYERS), .WORDS(WORDS), .BYTES(BYTES)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bus.frame_rdy_out === 1'b1) frame_pulses++;

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic send_byte(input logic dc, input logic [7:0] d);
    @(negedge clk);
    bus.byte_rdy_in  = 1'b1;
    bus.dc_in        = dc;
    bus.byte_data_in = d;
    @(negedge clk);
    bus.byte_rdy_in  = 1'b0;
    bus.dc_in        = 1'($urandom_range(0, 1));
    bus.byte_data_in = 8'($urandom);
  endtask

  task automatic model_cmd(input logic [7:0] c);
    if (c == 8'h2C) begin
      m_active = 1'b1;
      m_pos    = 0;
    end else if (c != 8'h29) begin
      m_active = 1'b0;
    end
  endtask

  task automatic model_data();
    e_last = 1'b0;
    e_word = '0;
    if (m_active) begin
      e_sel  = 4'(1 << (m_pos % BYTES));
      e_en   = LAYERS'(1 << (m_pos / LAYER_BYTES));
      e_word = 6'((m_pos / BYTES) % WORDS);
      m_pos++;
      e_last = (m_pos == FRAME_BYTES);
      if (e_last) m_active = 1'b0;
    end else begin
      e_sel = '0;
      e_en  = '0;
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_active = 1'b0;
    m_pos    = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.layer_en_out, bus.word_idx_out, bus.byte_sel_out, bus.byte_data_out, bus.frame_rdy_out} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_outputs en=%h word=%0d sel=%h data=%h frame=%b required all 0",
               bus.layer_en_out, bus.word_idx_out, bus.byte_sel_out, bus.byte_data_out, bus.frame_rdy_out);
    end
    checks++;
    if (bus.wr_active_out !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_wr_active got=%b required=0", bus.wr_active_out);
    end
    rst = 1'b0;
    m_active = 1'b0;
    m_pos    = 0;
  endtask

  task automatic test_first_bytes();
    logic [7:0] pattern [3] = '{8'hAA, 8'hBB, 8'hCC};
    send_byte(1'b0, 8'h2C);
    model_cmd(8'h2C);
    checks++;
    if ({bus.wr_active_out, bus.layer_en_out, bus.byte_sel_out} !== {1'b1, 8'h01, 4'h0}) begin
      failures++;
      $display("[TB] FAIL start_state active=%b en=%h sel=%h required 1/01/0",
               bus.wr_active_out, bus.layer_en_out, bus.byte_sel_out);
    end
    for (int i = 0; i < 3; i++) begin
      model_data();
      send_byte(1'b1, pattern[i]);
      checks++;
      if ({bus.layer_en_out, bus.word_idx_out, bus.byte_sel_out, bus.byte_data_out} !== {e_en, e_word, e_sel, pattern[i]}) begin
        failures++;
        $display("[TB] FAIL first_write[%0d] got en=%h word=%0d sel=%h data=%h required en=%h word=%0d sel=%h data=%h",
                 i, bus.layer_en_out, bus.word_idx_out, bus.byte_sel_out, bus.byte_data_out,
                 e_en, e_word, e_sel, pattern[i]);
      end
      @(negedge clk);
      checks++;
      if (bus.byte_sel_out !== 4'h0) begin
        failures++;
        $display("[TB] FAIL strobe_width[%0d] sel=%h required=0", i, bus.byte_sel_out);
      end
    end
  endtask

  task automatic test_layer_carry();
    logic [7:0] d;
    send_byte(1'b0, 8'h2C);
    model_cmd(8'h2C);
    for (int i = 0; i <= LAYER_BYTES; i++) begin
      d = 8'($urandom);
      model_data();
      send_byte(1'b1, d);
      checks++;
      if ({bus.layer_en_out, bus.word_idx_out, bus.byte_sel_out, bus.byte_data_out} !== {e_en, e_word, e_sel, d}) begin
        failures++;
        $display("[TB] FAIL carry_write[%0d] got en=%h word=%0d sel=%h data=%h required en=%h word=%0d sel=%h data=%h",
                 i, bus.layer_en_out, bus.word_idx_out, bus.byte_sel_out, bus.byte_data_out, e_en, e_word, e_sel, d);
      end
    end
    checks++;
    if ({bus.layer_en_out, bus.word_idx_out, bus.byte_sel_out} !== {8'h02, 6'd0, 4'h1}) begin
      failures++;
      $display("[TB] FAIL byte193 got en=%h word=%0d sel=%h required en=02 word=0 sel=1",
               bus.layer_en_out, bus.word_idx_out, bus.byte_sel_out);
    end
  endtask

  task automatic test_full_frame();
    logic [7:0] d;
    int p0;
    pulse_reset();
    p0 = frame_pulses;
    send_byte(1'b0, 8'h2C);
    model_cmd(8'h2C);
    for (int i = 0; i < FRAME_BYTES; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      d = 8'($urandom);
      model_data();
      send_byte(1'b1, d);
      checks++;
      if ({bus.layer_en_out, bus.word_idx_out, bus.byte_sel_out, bus.byte_data_out} !== {e_en, e_word, e_sel, d}) begin
        failures++;
        $display("[TB] FAIL frame_write[%0d] got en=%h word=%0d sel=%h data=%h required en=%h word=%0d sel=%h data=%h",
                 i, bus.layer_en_out, bus.word_idx_out, bus.byte_sel_out, bus.byte_data_out, e_en, e_word, e_sel, d);
      end
    end
    @(negedge clk);
    checks++;
    if ({bus.wr_active_out, bus.layer_en_out} !== '0) begin
      failures++;
      $display("[TB] FAIL frame_end active=%b en=%h required 0/00", bus.wr_active_out, bus.layer_en_out);
    end
    checks++;
    if (bus.frame_rdy_out !== 1'(AUTO_PULSES)) begin
      failures++;
      $display("[TB] FAIL auto_show_timing frame=%b required=%0d", bus.frame_rdy_out, AUTO_PULSES);
    end
    model_data();
    send_byte(1'b1, 8'h5A);
    checks++;
    if ({bus.byte_sel_out, bus.wr_active_out} !== {e_sel, 1'b0}) begin
      failures++;
      $display("[TB] FAIL extra_byte sel=%h active=%b required sel=%h active=0",
               bus.byte_sel_out, bus.wr_active_out, e_sel);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (frame_pulses - p0 !== AUTO_PULSES) begin
      failures++;
      $display("[TB] FAIL auto_show_count got=%0d required=%0d", frame_pulses - p0, AUTO_PULSES);
    end
  endtask

  task automatic test_show();
    logic [7:0] d;
    int p0;
    pulse_reset();
    p0 = frame_pulses;
    send_byte(1'b0, 8'h29);
    model_cmd(8'h29);
    checks++;
    if ({bus.frame_rdy_out, bus.wr_active_out} !== 2'b10) begin
      failures++;
      $display("[TB] FAIL show_idle frame=%b active=%b required 1/0", bus.frame_rdy_out, bus.wr_active_out);
    end
    @(negedge clk);
    checks++;
    if (bus.frame_rdy_out !== 1'b0) begin
      failures++;
      $display("[TB] FAIL show_idle_width frame=%b required=0", bus.frame_rdy_out);
    end
    send_byte(1'b0, 8'h2C);
    model_cmd(8'h2C);
    for (int i = 0; i < 4; i++) begin
      model_data();
      send_byte(1'b1, 8'($urandom));
    end
    send_byte(1'b0, 8'h29);
    model_cmd(8'h29);
    checks++;
    if ({bus.frame_rdy_out, bus.wr_active_out, bus.layer_en_out} !== {2'b11, 8'h01}) begin
      failures++;
      $display("[TB] FAIL show_mid frame=%b active=%b en=%h required 1/1/01",
               bus.frame_rdy_out, bus.wr_active_out, bus.layer_en_out);
    end
    @(negedge clk);
    checks++;
    if (bus.frame_rdy_out !== 1'b0) begin
      failures++;
      $display("[TB] FAIL show_mid_width frame=%b required=0", bus.frame_rdy_out);
    end
    d = 8'($urandom);
    model_data();
    send_byte(1'b1, d);
    checks++;
    if ({bus.layer_en_out, bus.word_idx_out, bus.byte_sel_out, bus.byte_data_out} !== {e_en, e_word, e_sel, d}) begin
      failures++;
      $display("[TB] FAIL show_resume got en=%h word=%0d sel=%h data=%h required en=%h word=%0d sel=%h data=%h",
               bus.layer_en_out, bus.word_idx_out, bus.byte_sel_out, bus.byte_data_out, e_en, e_word, e_sel, d);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (frame_pulses - p0 !== 2) begin
      failures++;
      $display("[TB] FAIL show_count got=%0d required=2", frame_pulses - p0);
    end
  endtask

  task automatic test_abort();
    logic [7:0] d;
    send_byte(1'b0, 8'h2C);
    model_cmd(8'h2C);
    for (int i = 0; i < 3 * LAYER_BYTES + 40; i++) begin
      model_data();
      send_byte(1'b1, 8'($urandom));
    end
    send_byte(1'b0, 8'h55);
    model_cmd(8'h55);
    checks++;
    if ({bus.wr_active_out, bus.layer_en_out} !== '0) begin
      failures++;
      $display("[TB] FAIL abort_state active=%b en=%h required 0/00", bus.wr_active_out, bus.layer_en_out);
    end
    model_data();
    send_byte(1'b1, 8'h77);
    checks++;
    if (bus.byte_sel_out !== e_sel) begin
      failures++;
      $display("[TB] FAIL abort_data_ignored sel=%h required=%h", bus.byte_sel_out, e_sel);
    end
    send_byte(1'b0, 8'h2C);
    model_cmd(8'h2C);
    d = 8'($urandom);
    model_data();
    send_byte(1'b1, d);
    checks++;
    if ({bus.layer_en_out, bus.word_idx_out, bus.byte_sel_out, bus.byte_data_out} !== {e_en, e_word, e_sel, d}) begin
      failures++;
      $display("[TB] FAIL abort_restart got en=%h word=%0d sel=%h data=%h required en=%h word=%0d sel=%h data=%h",
               bus.layer_en_out, bus.word_idx_out, bus.byte_sel_out, bus.byte_data_out, e_en, e_word, e_sel, d);
    end
  endtask

  task automatic test_reset_mid();
    int p0;
    send_byte(1'b0, 8'h2C);
    model_cmd(8'h2C);
    for (int i = 0; i < 100; i++) begin
      model_data();
      send_byte(1'b1, 8'($urandom));
    end
    p0 = frame_pulses;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.layer_en_out, bus.word_idx_out, bus.byte_sel_out, bus.byte_data_out,
         bus.frame_rdy_out, bus.wr_active_out} !== '0) begin
      failures++;
      $display("[TB] FAIL mid_reset en=%h word=%0d sel=%h data=%h frame=%b active=%b required all 0",
               bus.layer_en_out, bus.word_idx_out, bus.byte_sel_out, bus.byte_data_out,
               bus.frame_rdy_out, bus.wr_active_out);
    end
    rst = 1'b0;
    m_active = 1'b0;
    m_pos    = 0;
    model_data();
    send_byte(1'b1, 8'h33);
    checks++;
    if (bus.byte_sel_out !== e_sel) begin
      failures++;
      $display("[TB] FAIL post_reset_data sel=%h required=%h", bus.byte_sel_out, e_sel);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (frame_pulses - p0 !== 0) begin
      failures++;
      $display("[TB] FAIL mid_reset_no_show pulses=%0d required=0", frame_pulses - p0);
    end
  endtask

  initial begin
    bus.byte_rdy_in  = 1'b0;
    bus.dc_in        = 1'b0;
    bus.byte_data_in = 8'h00;
    test_reset();
    test_first_bytes();
    test_layer_carry();
    test_full_frame();
    test_show();
    test_abort();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
